// File: rtl/rffe_master.sv
// RFFE bus master: serialises one register write or read per request onto
// a single SCLK/SDATA lane and returns read data with a parity status.
module rffe_master #(
  parameter int unsigned HALF_CYC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_vd,
  input  logic       cmd_rd,
  input  logic [3:0] cmd_sa,
  input  logic [4:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       rd_perr,
  output logic       sclk,
  output logic       sdo,
  output logic       sdo_en,
  input  logic       sdi
);

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_SSC1  = 4'd1;
  localparam logic [3:0] ST_SSC2  = 4'd2;
  localparam logic [3:0] ST_CMD   = 4'd3;
  localparam logic [3:0] ST_WDATA = 4'd4;
  localparam logic [3:0] ST_PARK  = 4'd5;
  localparam logic [3:0] ST_PARK1 = 4'd6;
  localparam logic [3:0] ST_RDATA = 4'd7;
  localparam logic [3:0] ST_PARK2 = 4'd8;
  localparam logic [3:0] ST_DONE  = 4'd9;

  localparam logic [7:0] HALF_LAST = 8'(HALF_CYC - 1);

  logic [3:0]  state;
  logic [3:0]  slot_cnt;
  logic [7:0]  half_cnt;
  logic        low_half;
  logic        is_rd;
  logic [21:0] tx_sr;
  logic [7:0]  rx_sr;
  logic        rx_par;

  logic [11:0] cmd_word;
  logic        half_end;
  logic [3:0]  nxt_state;
  logic [3:0]  nxt_slot;

  assign cmd_word = {cmd_sa, 2'b01, cmd_rd, cmd_addr};
  assign half_end = (half_cnt == HALF_LAST);

  // Where the frame goes when the current slot finishes.
  always_comb begin
    nxt_state = state;
    nxt_slot  = 4'd0;
    case (state)
      ST_SSC1:  nxt_state = ST_SSC2;
      ST_SSC2:  nxt_state = ST_CMD;
      ST_CMD: begin
        if (slot_cnt == 4'd12) nxt_state = is_rd ? ST_PARK1 : ST_WDATA;
        else                   nxt_slot  = slot_cnt + 4'd1;
      end
      ST_WDATA: begin
        if (slot_cnt == 4'd8) nxt_state = ST_PARK;
        else                  nxt_slot  = slot_cnt + 4'd1;
      end
      ST_PARK1: nxt_state = ST_RDATA;
      ST_RDATA: begin
        if (slot_cnt == 4'd8) nxt_state = ST_PARK2;
        else                  nxt_slot  = slot_cnt + 4'd1;
      end
      ST_PARK, ST_PARK2: nxt_state = ST_DONE;
      default:  nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      slot_cnt <= 4'd0;
      half_cnt <= 8'd0;
      low_half <= 1'b0;
      is_rd    <= 1'b0;
      tx_sr    <= 22'd0;
      rx_sr    <= 8'd0;
      rx_par   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rdata    <= 8'd0;
      rd_perr  <= 1'b0;
      sclk     <= 1'b0;
      sdo      <= 1'b0;
      sdo_en   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_vd) begin
            state    <= ST_SSC1;
            busy     <= 1'b1;
            is_rd    <= cmd_rd;
            tx_sr    <= {cmd_word, ~^cmd_word, cmd_wdata, ~^cmd_wdata};
            slot_cnt <= 4'd0;
            half_cnt <= 8'd0;
            low_half <= 1'b0;
            sclk     <= 1'b0;
            sdo      <= 1'b1;
            sdo_en   <= 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: begin
          if (!half_end) begin
            half_cnt <= half_cnt + 8'd1;
          end else begin
            half_cnt <= 8'd0;
            low_half <= ~low_half;
            if (!low_half) begin
              // Falling SCLK: release park slots and capture slave data.
              sclk <= 1'b0;
              if (state == ST_PARK || state == ST_PARK1 || state == ST_PARK2)
                sdo_en <= 1'b0;
              if (state == ST_RDATA) begin
                if (slot_cnt[3]) rx_par <= sdi;
                else             rx_sr  <= {rx_sr[6:0], sdi};
              end
            end else begin
              state    <= nxt_state;
              slot_cnt <= nxt_slot;
              case (nxt_state)
                ST_SSC2: begin
                  sclk   <= 1'b0;
                  sdo    <= 1'b0;
                  sdo_en <= 1'b1;
                end
                ST_CMD, ST_WDATA: begin
                  sclk   <= 1'b1;
                  sdo    <= tx_sr[21];
                  sdo_en <= 1'b1;
                  tx_sr  <= {tx_sr[20:0], 1'b0};
                end
                ST_PARK, ST_PARK1, ST_PARK2: begin
                  sclk   <= 1'b1;
                  sdo    <= 1'b0;
                  sdo_en <= 1'b1;
                end
                ST_RDATA: begin
                  sclk   <= 1'b1;
                  sdo    <= 1'b0;
                  sdo_en <= 1'b0;
                end
                ST_DONE: begin
                  sclk   <= 1'b0;
                  sdo    <= 1'b0;
                  sdo_en <= 1'b0;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  if (is_rd) begin
                    rdata   <= rx_sr;
                    rd_perr <= ~^{rx_sr, rx_par};
                  end
                end
                default: begin
                  sclk   <= 1'b0;
                  sdo    <= 1'b0;
                  sdo_en <= 1'b0;
                  busy   <= 1'b0;
                end
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rffe_master.sv
// Self-checking bench for rffe_master: random and directed frames compared
// against a slot-level model of the RFFE frame, at HALF_CYC of 2 and 1.
module tb_rffe_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_vd;
  logic       cmd_rd;
  logic [3:0] cmd_sa;
  logic [4:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       sdi;
  logic       sel;

  logic       busy_a, done_a, perr_a, sclk_a, sdo_a, en_a;
  logic [7:0] rdata_a;
  logic       busy_b, done_b, perr_b, sclk_b, sdo_b, en_b;
  logic [7:0] rdata_b;

  logic       o_busy, o_done, o_perr, o_sclk, o_sdo, o_en;
  logic [7:0] o_rdata;
  logic       vd_a, vd_b;

  int checks   = 0;
  int failures = 0;
  int half;
  logic [7:0] exp_rdata;
  logic       exp_perr;

  localparam int K_SSC  = 0;
  localparam int K_DRV  = 1;
  localparam int K_PARK = 2;
  localparam int K_RX   = 3;

  int   slot_kind[$];
  logic slot_bit[$];

  assign vd_a = cmd_vd & ~sel;
  assign vd_b = cmd_vd & sel;

  rffe_master #(.HALF_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_vd(vd_a), .cmd_rd(cmd_rd), .cmd_sa(cmd_sa),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .busy(busy_a), .done(done_a),
    .rdata(rdata_a), .rd_perr(perr_a), .sclk(sclk_a), .sdo(sdo_a),
    .sdo_en(en_a), .sdi(sdi)
  );

  rffe_master #(.HALF_CYC(1)) dut_fast (
    .clk(clk), .rst_n(rst_n), .cmd_vd(vd_b), .cmd_rd(cmd_rd), .cmd_sa(cmd_sa),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .busy(busy_b), .done(done_b),
    .rdata(rdata_b), .rd_perr(perr_b), .sclk(sclk_b), .sdo(sdo_b),
    .sdo_en(en_b), .sdi(sdi)
  );

  assign o_busy  = sel ? busy_b  : busy_a;
  assign o_done  = sel ? done_b  : done_a;
  assign o_rdata = sel ? rdata_b : rdata_a;
  assign o_perr  = sel ? perr_b  : perr_a;
  assign o_sclk  = sel ? sclk_b  : sclk_a;
  assign o_sdo   = sel ? sdo_b   : sdo_a;
  assign o_en    = sel ? en_b    : en_a;

  always #5 clk = ~clk;

  // Shared comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic oddPar(input logic [31:0] v);
    return ($countones(v) % 2) == 0;
  endfunction

  task automatic pushBits(input logic [31:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      slot_kind.push_back(K_DRV);
      slot_bit.push_back(val[i]);
    end
  endtask

  // One full frame: accept, walk every cycle against the slot model, check done.
  task automatic applyStimulus(input logic rd, input logic [3:0] sa, input logic [4:0] addr,
                               input logic [7:0] wdata, input logic [7:0] sdat,
                               input logic spar, input int inject_at);
    logic [11:0] cmd;
    logic [2:0]  obs, exp;
    logic        exp_sclk, exp_en, exp_sdo;
    int          total, slot, ph, kind;
    cmd = {sa, 2'b01, rd, addr};
    slot_kind.delete();
    slot_bit.delete();
    slot_kind.push_back(K_SSC); slot_bit.push_back(1'b1);
    slot_kind.push_back(K_SSC); slot_bit.push_back(1'b0);
    pushBits(32'(cmd), 12);
    pushBits(32'(oddPar(32'(cmd))), 1);
    if (rd) begin
      slot_kind.push_back(K_PARK); slot_bit.push_back(1'b0);
      for (int i = 7; i >= 0; i--) begin
        slot_kind.push_back(K_RX); slot_bit.push_back(sdat[i]);
      end
      slot_kind.push_back(K_RX); slot_bit.push_back(spar);
    end else begin
      pushBits(32'(wdata), 8);
      pushBits(32'(oddPar(32'(wdata))), 1);
    end
    slot_kind.push_back(K_PARK); slot_bit.push_back(1'b0);
    total = slot_kind.size() * 2 * half;

    @(posedge clk); #1;
    cmd_rd = rd; cmd_sa = sa; cmd_addr = addr; cmd_wdata = wdata; cmd_vd = 1'b1;
    @(posedge clk); #1;
    cmd_rd = 1'($urandom); cmd_sa = 4'($urandom); cmd_addr = 5'($urandom);
    cmd_wdata = 8'($urandom);
    for (int c = 0; c <= total; c++) begin
      cmd_vd = (c == inject_at);
      if (c < total) begin
        slot = c / (2 * half);
        ph   = c % (2 * half);
        kind = slot_kind[slot];
        exp_sclk = (kind != K_SSC) && (ph < half);
        exp_en   = (kind == K_SSC) || (kind == K_DRV) || ((kind == K_PARK) && (ph < half));
        exp_sdo  = (kind == K_PARK) ? 1'b0 : slot_bit[slot];
        if (kind == K_RX && ph == 0) sdi = slot_bit[slot];
        obs = {o_sclk, o_en, exp_en ? o_sdo : 1'b0};
        exp = {exp_sclk, exp_en, exp_en ? exp_sdo : 1'b0};
        checkOutput($sformatf("wave c=%0d", c), 32'(obs), 32'(exp));
        checkOutput("busy_in_frame", 32'(o_busy), 32'd1);
        checkOutput("done_early", 32'(o_done), 32'd0);
        @(posedge clk); #1;
      end else begin
        if (rd) begin
          exp_rdata = sdat;
          exp_perr  = ($countones({sdat, spar}) % 2) == 0;
        end
        checkOutput("done", 32'(o_done), 32'd1);
        checkOutput("busy_at_done", 32'(o_busy), 32'd0);
        checkOutput("lane_at_done", 32'({o_sclk, o_en}), 32'd0);
        checkOutput("rdata", 32'(o_rdata), 32'(exp_rdata));
        checkOutput("rd_perr", 32'(o_perr), 32'(exp_perr));
      end
    end
    cmd_vd = 1'b0;
    sdi    = 1'b0;
  endtask

  task automatic randomFrame();
    applyStimulus(1'($urandom), 4'($urandom), 5'($urandom), 8'($urandom),
                  8'($urandom), 1'($urandom), -1);
  endtask

  // Reset in the middle of CMD must clear everything without a done pulse.
  task automatic midReset();
    @(posedge clk); #1;
    cmd_rd = 1'b0; cmd_sa = 4'hA; cmd_addr = 5'h11; cmd_wdata = 8'h3E; cmd_vd = 1'b1;
    @(posedge clk); #1;
    cmd_vd = 1'b0;
    repeat (8 * 2 * half) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 32'({o_busy, o_done, o_rdata, o_perr, o_sclk, o_sdo, o_en}), 32'd0);
    exp_rdata = 8'd0;
    exp_perr  = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      checkOutput("idle_after_reset", 32'({o_done, o_busy, o_sclk, o_en}), 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; cmd_vd = 1'b0; cmd_rd = 1'b0; cmd_sa = 4'd0; cmd_addr = 5'd0;
    cmd_wdata = 8'd0; sdi = 1'b0; sel = 1'b0; half = 2;
    exp_rdata = 8'd0; exp_perr = 1'b0;
    #12;
    checkOutput("reset_values", 32'({o_busy, o_done, o_rdata, o_perr, o_sclk, o_sdo, o_en}), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checkOutput("idle_lane", 32'({o_sclk, o_en, o_busy}), 32'd0);
    end

    applyStimulus(1'b0, 4'h5, 5'h1C, 8'hA5, 8'h00, 1'b0, -1);
    applyStimulus(1'b1, 4'hF, 5'h00, 8'h00, 8'h3C, 1'b1, -1);
    applyStimulus(1'b1, 4'hF, 5'h00, 8'h00, 8'h01, 1'b1, -1);
    applyStimulus(1'b0, 4'h3, 5'h0A, 8'h5A, 8'h00, 1'b0, 9);
    applyStimulus(1'b0, 4'hC, 5'h1F, 8'hFF, 8'h00, 1'b0, -1);
    for (int i = 0; i < 6; i++) randomFrame();
    midReset();
    applyStimulus(1'b0, 4'h6, 5'h05, 8'h81, 8'h00, 1'b0, -1);

    sel = 1'b1; half = 1;
    applyStimulus(1'b0, 4'h5, 5'h1C, 8'hA5, 8'h00, 1'b0, -1);
    applyStimulus(1'b1, 4'hF, 5'h00, 8'h00, 8'h3C, 1'b1, -1);
    for (int i = 0; i < 6; i++) randomFrame();
    midReset();
    applyStimulus(1'b0, 4'h9, 5'h12, 8'h0F, 8'h00, 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
